// File: rtl/ysyx_22040895_lsu.sv
// Load/store unit behind the execute-stage ALU: one outstanding req/gnt memory transaction at a time.
// Optional misaligned-access trap enabled by defining YSYX_22040895_LSU_MISALIGN_EN.
module ysyx_22040895_lsu #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef YSYX_22040895_LSU_MISALIGN_EN
  output logic                  misalign_o,
`endif
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  is_load_i,
  input  logic                  is_store_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [4:0]            rd_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_W-1:0]     out_data_o,
  output logic [4:0]            out_rd_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [DATA_W/8-1:0]   mem_wmask_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_W-1:0]     mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_OUT} state_t;

  state_t                r_state, w_state_nxt;
  logic [2:0]            r_off;
  logic [2:0]            r_funct3;
  logic                  r_is_ld;
  logic                  r_mem_we;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic [DATA_W/8-1:0]   r_mem_wmask;
  logic [DATA_W-1:0]     r_out_data;
  logic [4:0]            r_out_rd;
  logic                  w_accept;
  logic                  w_is_mem;
  logic                  w_is_st;
  logic                  w_misalign;
  logic                  w_rsp_done;

  // Shift the addressed lane down, then sign/zero extend by funct3 size.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] rdata,
                                                    input logic [2:0] off,
                                                    input logic [2:0] f3);
    logic [DATA_W-1:0]        x;
    logic signed [DATA_W-1:0] s;
    x = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  s = $signed({{(DATA_W-8){x[7]}},   x[7:0]});
      3'b100:  s = $signed({{(DATA_W-8){1'b0}},   x[7:0]});
      3'b001:  s = $signed({{(DATA_W-16){x[15]}}, x[15:0]});
      3'b101:  s = $signed({{(DATA_W-16){1'b0}},  x[15:0]});
      3'b010:  s = $signed({{(DATA_W-32){x[31]}}, x[31:0]});
      3'b110:  s = $signed({{(DATA_W-32){1'b0}},  x[31:0]});
      default: s = $signed(x);
    endcase
    return $unsigned(s);
  endfunction

  function automatic logic [DATA_W/8-1:0] store_mask(input logic [2:0] f3,
                                                     input logic [2:0] off);
    logic [DATA_W/8-1:0] m;
    case (f3[1:0])
      2'b00:   m = 8'h01 << off;
      2'b01:   m = 8'h03 << off;
      2'b10:   m = 8'h0F << off;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] store_data(input logic [DATA_W-1:0] wdata,
                                                   input logic [2:0] off);
    return wdata << {off, 3'b000};
  endfunction

`ifdef YSYX_22040895_LSU_MISALIGN_EN
  logic r_misalign;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off[1:0] != 2'b00;
      2'b11:   return off != 3'b000;
      default: return 1'b0;
    endcase
  endfunction

  assign w_misalign = w_is_mem & is_misaligned(funct3_i, addr_i[2:0]);
  assign misalign_o = r_misalign;
`else
  assign w_misalign = 1'b0;
`endif

  assign in_ready_o  = (r_state == S_IDLE) & ~rst;
  assign w_accept    = in_valid_i & in_ready_o;
  assign w_is_mem    = is_load_i | is_store_i;
  assign w_is_st     = is_store_i & ~is_load_i;
  assign w_rsp_done  = mem_rvalid_i & ((r_state == S_RESP) | ((r_state == S_REQ) & mem_gnt_i));

  assign out_valid_o = (r_state == S_OUT);
  assign out_data_o  = r_out_data;
  assign out_rd_o    = r_out_rd;
  assign mem_req_o   = (r_state == S_REQ);
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_wmask_o = r_mem_wmask;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (!w_is_mem || w_misalign) ? S_OUT : S_REQ;
      S_REQ:  if (mem_gnt_i) w_state_nxt = mem_rvalid_i ? S_OUT : S_RESP;
      S_RESP: if (mem_rvalid_i) w_state_nxt = S_OUT;
      S_OUT:  if (out_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Acceptance captures the op; response captures the extended load value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_off       <= '0;
      r_funct3    <= '0;
      r_is_ld     <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
      r_out_data  <= '0;
      r_out_rd    <= '0;
`ifdef YSYX_22040895_LSU_MISALIGN_EN
      r_misalign  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_off    <= addr_i[2:0];
            r_funct3 <= funct3_i;
            r_is_ld  <= is_load_i;
            if (!w_is_mem) begin
              r_out_data <= addr_i;
              r_out_rd   <= rd_i;
            end else if (w_misalign) begin
              r_out_data <= '0;
              r_out_rd   <= '0;
`ifdef YSYX_22040895_LSU_MISALIGN_EN
              r_misalign <= 1'b1;
`endif
            end else begin
              r_mem_addr  <= {addr_i[ADDR_W-1:3], 3'b000};
              r_mem_we    <= w_is_st;
              r_mem_wdata <= w_is_st ? store_data(wdata_i, addr_i[2:0]) : '0;
              r_mem_wmask <= w_is_st ? store_mask(funct3_i, addr_i[2:0]) : '0;
              r_out_rd    <= is_load_i ? rd_i : 5'd0;
            end
          end
        end
        S_REQ, S_RESP: begin
          if (w_rsp_done)
            r_out_data <= r_is_ld ? load_extend(mem_rdata_i, r_off, r_funct3) : '0;
        end
        S_OUT: begin
`ifdef YSYX_22040895_LSU_MISALIGN_EN
          if (out_ready_i) r_misalign <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040895_lsu.sv
// Directed self-checking bench for ysyx_22040895_lsu; inputs change 1 time unit after each rising edge.
module tb_ysyx_22040895_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, in_ready_o, is_load_i, is_store_i;
  logic [2:0]  funct3_i;
  logic [63:0] addr_i, wdata_i;
  logic [4:0]  rd_i;
  logic        out_valid_o, out_ready_i;
  logic [63:0] out_data_o;
  logic [4:0]  out_rd_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o;
  logic [63:0] mem_addr_o, mem_wdata_o;
  logic [7:0]  mem_wmask_o;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;
`ifdef YSYX_22040895_LSU_MISALIGN_EN
  logic        misalign_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_22040895_lsu dut (
    .clk(clk), .rst(rst),
`ifdef YSYX_22040895_LSU_MISALIGN_EN
    .misalign_o(misalign_o),
`endif
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .is_load_i(is_load_i), .is_store_i(is_store_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rd_i(rd_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_rd_o(out_rd_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd, input logic [4:0] rd);
    is_load_i = ld; is_store_i = st; funct3_i = f3;
    addr_i = a; wdata_i = wd; rd_i = rd;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd, input logic [4:0] rd);
    set_op(ld, st, f3, a, wd, rd);
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic handshake();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %0b want 0", in_ready_o); end
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", out_valid_o); end
    n_checks++; if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_mem_ctl: got req=%0b we=%0b want 0 0", mem_req_o, mem_we_o); end
    n_checks++; if (out_data_o !== 64'h0 || out_rd_o !== 5'd0) begin n_fail++; $display("FAIL rst_out: got data=%h rd=%0d want 0 0", out_data_o, out_rd_o); end
    n_checks++; if (mem_addr_o !== 64'h0 || mem_wdata_o !== 64'h0 || mem_wmask_o !== 8'h0) begin n_fail++; $display("FAIL rst_mem_data: got addr=%h wdata=%h mask=%h want 0", mem_addr_o, mem_wdata_o, mem_wmask_o); end
`ifdef YSYX_22040895_LSU_MISALIGN_EN
    n_checks++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %0b want 0", misalign_o); end
`endif
    rst = 1'b0;
    tick();
    n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %0b want 1", in_ready_o); end
  endtask

  task automatic test_nonmem();
    issue(1'b0, 1'b0, 3'b000, 64'h2A, 64'h0, 5'd5);
    n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL nm_valid: got %0b want 1", out_valid_o); end
    n_checks++; if (out_data_o !== 64'h2A || out_rd_o !== 5'd5) begin n_fail++; $display("FAIL nm_out: got data=%h rd=%0d want 2a 5", out_data_o, out_rd_o); end
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL nm_no_req: got %0b want 0", mem_req_o); end
    n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL nm_busy: got %0b want 0", in_ready_o); end
    handshake();
    n_checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || mem_req_o !== 1'b0) begin n_fail++; $display("FAIL nm_done: got valid=%0b ready=%0b req=%0b want 0 1 0", out_valid_o, in_ready_o, mem_req_o); end
    // A stray response in IDLE must not start anything
    mem_rvalid_i = 1'b1; tick(); mem_rvalid_i = 1'b0;
    n_checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin n_fail++; $display("FAIL idle_rvalid: got valid=%0b ready=%0b want 0 1", out_valid_o, in_ready_o); end
  endtask

  task automatic test_lb();
    issue(1'b1, 1'b0, 3'b000, 64'h8000_0003, 64'h0, 5'd7);
    n_checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0) begin n_fail++; $display("FAIL lb_req: got req=%0b we=%0b want 1 0", mem_req_o, mem_we_o); end
    n_checks++; if (mem_addr_o !== 64'h8000_0000) begin n_fail++; $display("FAIL lb_addr: got %h want 80000000", mem_addr_o); end
    mem_gnt_i = 1'b1; tick(); mem_gnt_i = 1'b0;
    n_checks++; if (mem_req_o !== 1'b0 || out_valid_o !== 1'b0) begin n_fail++; $display("FAIL lb_resp_wait: got req=%0b valid=%0b want 0 0", mem_req_o, out_valid_o); end
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'h0000_0000_F200_0000;
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = 64'h0;
    n_checks++; if (out_valid_o !== 1'b1 || out_data_o !== 64'hFFFF_FFFF_FFFF_FFF2 || out_rd_o !== 5'd7) begin n_fail++; $display("FAIL lb_data: got valid=%0b data=%h rd=%0d want 1 fffffffffffffff2 7", out_valid_o, out_data_o, out_rd_o); end
    handshake();
  endtask

  task automatic test_lwu_lw();
    issue(1'b1, 1'b0, 3'b110, 64'h8000_0004, 64'h0, 5'd3);
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h8000_0001_0000_0000;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    n_checks++; if (out_valid_o !== 1'b1 || out_data_o !== 64'h0000_0000_8000_0001) begin n_fail++; $display("FAIL lwu_data: got valid=%0b data=%h want 1 0000000080000001", out_valid_o, out_data_o); end
    handshake();
    issue(1'b1, 1'b0, 3'b010, 64'h8000_0004, 64'h0, 5'd3);
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 64'h0;
    n_checks++; if (out_valid_o !== 1'b1 || out_data_o !== 64'hFFFF_FFFF_8000_0001) begin n_fail++; $display("FAIL lw_data: got valid=%0b data=%h want 1 ffffffff80000001", out_valid_o, out_data_o); end
    handshake();
  endtask

  task automatic test_sw();
    issue(1'b0, 1'b1, 3'b010, 64'h8000_0004, 64'h1234_5678, 5'd9);
    n_checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 64'h8000_0000) begin n_fail++; $display("FAIL sw_req: got req=%0b we=%0b addr=%h want 1 1 80000000", mem_req_o, mem_we_o, mem_addr_o); end
    n_checks++; if (mem_wmask_o !== 8'hF0 || mem_wdata_o !== 64'h1234_5678_0000_0000) begin n_fail++; $display("FAIL sw_lanes: got mask=%h wdata=%h want f0 1234567800000000", mem_wmask_o, mem_wdata_o); end
    mem_gnt_i = 1'b1; tick(); mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = 64'h0;
    n_checks++; if (out_valid_o !== 1'b1 || out_data_o !== 64'h0 || out_rd_o !== 5'd0) begin n_fail++; $display("FAIL sw_wb: got valid=%0b data=%h rd=%0d want 1 0 0", out_valid_o, out_data_o, out_rd_o); end
    handshake();
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 1'b0, 3'b011, 64'h8000_0010, 64'h0, 5'd12);
    // Offer another op while busy; it must wait
    set_op(1'b0, 1'b0, 3'b000, 64'h55, 64'h0, 5'd1);
    in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 64'h8000_0010 || in_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_req_hold%0d: got req=%0b addr=%h ready=%0b want 1 80000010 0", i, mem_req_o, mem_addr_o, in_ready_o); end
      tick();
    end
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h1122_3344_5566_7788;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 64'h0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (out_valid_o !== 1'b1 || out_data_o !== 64'h1122_3344_5566_7788 || out_rd_o !== 5'd12 || in_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_out_hold%0d: got valid=%0b data=%h rd=%0d ready=%0b want 1 1122334455667788 12 0", i, out_valid_o, out_data_o, out_rd_o, in_ready_o); end
      if (i < 2) tick();
    end
    handshake();
    n_checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_no_same_cycle: got valid=%0b ready=%0b want 0 1", out_valid_o, in_ready_o); end
    tick();
    in_valid_i = 1'b0;
    n_checks++; if (out_valid_o !== 1'b1 || out_data_o !== 64'h55 || out_rd_o !== 5'd1) begin n_fail++; $display("FAIL bp_next_op: got valid=%0b data=%h rd=%0d want 1 55 1", out_valid_o, out_data_o, out_rd_o); end
    handshake();
  endtask

  task automatic test_misalign();
    issue(1'b1, 1'b0, 3'b001, 64'h8000_0001, 64'h0, 5'd4);
`ifdef YSYX_22040895_LSU_MISALIGN_EN
    n_checks++; if (misalign_o !== 1'b1 || out_valid_o !== 1'b1 || mem_req_o !== 1'b0) begin n_fail++; $display("FAIL mis_flag: got mis=%0b valid=%0b req=%0b want 1 1 0", misalign_o, out_valid_o, mem_req_o); end
    n_checks++; if (out_data_o !== 64'h0 || out_rd_o !== 5'd0) begin n_fail++; $display("FAIL mis_out: got data=%h rd=%0d want 0 0", out_data_o, out_rd_o); end
    handshake();
    n_checks++; if (misalign_o !== 1'b0 || in_ready_o !== 1'b1) begin n_fail++; $display("FAIL mis_clear: got mis=%0b ready=%0b want 0 1", misalign_o, in_ready_o); end
`else
    n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 64'h8000_0000) begin n_fail++; $display("FAIL lh_req: got req=%0b addr=%h want 1 80000000", mem_req_o, mem_addr_o); end
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h0000_0000_0080_0100;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 64'h0;
    n_checks++; if (out_valid_o !== 1'b1 || out_data_o !== 64'hFFFF_FFFF_FFFF_8001 || out_rd_o !== 5'd4) begin n_fail++; $display("FAIL lh_data: got valid=%0b data=%h rd=%0d want 1 ffffffffffff8001 4", out_valid_o, out_data_o, out_rd_o); end
    handshake();
    issue(1'b0, 1'b1, 3'b001, 64'h8000_0007, 64'hBEEF, 5'd2);
    n_checks++; if (mem_wmask_o !== 8'h80 || mem_wdata_o !== 64'hEF00_0000_0000_0000) begin n_fail++; $display("FAIL sh_trunc: got mask=%h wdata=%h want 80 ef00000000000000", mem_wmask_o, mem_wdata_o); end
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    n_checks++; if (out_valid_o !== 1'b1 || out_rd_o !== 5'd0) begin n_fail++; $display("FAIL sh_done: got valid=%0b rd=%0d want 1 0", out_valid_o, out_rd_o); end
    handshake();
`endif
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 1'b0, 3'b011, 64'h8000_0020, 64'h0, 5'd6);
    n_checks++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL rm_req: got %0b want 1", mem_req_o); end
    rst = 1'b1;
    tick();
    n_checks++; if (mem_req_o !== 1'b0 || in_ready_o !== 1'b0 || out_valid_o !== 1'b0 || mem_addr_o !== 64'h0) begin n_fail++; $display("FAIL rm_abort: got req=%0b ready=%0b valid=%0b addr=%h want 0 0 0 0", mem_req_o, in_ready_o, out_valid_o, mem_addr_o); end
    rst = 1'b0;
    tick();
    n_checks++; if (in_ready_o !== 1'b1 || mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rm_idle: got ready=%0b req=%0b want 1 0", in_ready_o, mem_req_o); end
  endtask

  initial begin
    rst = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 64'h0;
    set_op(1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 5'd0);
    test_reset();
    test_nonmem();
    test_lb();
    test_lwu_lw();
    test_sw();
    test_back_to_back();
    test_misalign();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22040895_lsu.md
Name: ysyx_22040895_lsu

Overview:
- Load/store unit sitting directly downstream of the execute-stage ALU.
- Takes the ALU result as the effective address (or as a plain writeback value for non-memory ops) plus rs2 store data.
- Runs one transaction at a time on a simple req/grant + response memory bus.
- Hands the aligned, extended writeback value to the writeback stage through a valid/ready handshake.

Parameters:
- ADDR_W, 64, address width; equals the ALU result width.
- DATA_W, 64, data bus width; fixed at 8 byte lanes.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid_i  in  1  upstream op valid
- in_ready_o  out  1  LSU can accept an op
- is_load_i  in  1  op is a load
- is_store_i  in  1  op is a store
- funct3_i  in  3  RV64 size/sign field
- addr_i  in  64  ALU result: effective address, or passthrough value
- wdata_i  in  64  rs2 store data
- rd_i  in  5  destination register
- out_valid_o  out  1  writeback data valid
- out_ready_i  in  1  writeback stage accepts
- out_data_o  out  64  writeback value
- out_rd_o  out  5  writeback rd; 0 for stores
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  request accepted
- mem_we_o  out  1  1 = write
- mem_addr_o  out  64  addr_i with bits [2:0] cleared
- mem_wdata_o  out  64  lane-shifted store data
- mem_wmask_o  out  8  byte enables
- mem_rvalid_i  in  1  response / write ack
- mem_rdata_i  in  64  read data, full 8-byte word

Behaviour:
- Reset (rst high at a clock edge):
  - State goes to IDLE.
  - out_valid_o, mem_req_o, mem_we_o, misalign_o = 0.
  - out_data_o, out_rd_o, mem_addr_o, mem_wdata_o, mem_wmask_o = 0.
  - in_ready_o = 0 while rst is high.
- FSM states: IDLE, REQ, RESP, OUT. in_ready_o = 1 only in IDLE.
- IDLE: accept on in_valid_i & in_ready_o; all inputs are registered at acceptance.
  - Neither load nor store: out_data_o = addr_i, out_rd_o = rd_i, go to OUT. Latency 1 cycle.
  - Load or store: drive the mem_* outputs, go to REQ. If both flags are set, the load takes priority.
- REQ:
  - mem_req_o = 1; all mem_* outputs held stable until mem_gnt_i.
  - On mem_gnt_i: go to RESP, or directly to OUT if mem_rvalid_i is also high in the same cycle.
- RESP: wait for mem_rvalid_i, then go to OUT. Stores also wait for rvalid, treated as a write ack.
- mem_rvalid_i is ignored in IDLE and OUT.
- OUT:
  - out_valid_o = 1; out_data_o and out_rd_o held until out_ready_i.
  - Then return to IDLE. No op is accepted in the same cycle as the OUT handshake.
- Byte offset: off = addr[2:0].
- Store encoding:
  - funct3 000 (SB): wmask 0x01<<off.
  - funct3 001 (SH): wmask 0x03<<off.
  - funct3 010 (SW): wmask 0x0F<<off.
  - funct3 011 (SD): wmask 0xFF.
  - funct3[2] is ignored for stores.
  - wdata = wdata_i << (8*off), truncated to 64 bits. Mask bits shifted beyond lane 7 are dropped.
- Load encoding:
  - Shift: x = mem_rdata_i >> (8*off).
  - 000 LB sign-extends x[7:0]; 100 LBU zero-extends it.
  - 001 LH sign-extends x[15:0]; 101 LHU zero-extends it.
  - 010 LW sign-extends x[31:0]; 110 LWU zero-extends it.
  - 011 and 111 are treated as LD: x is used unchanged.
  - Bytes shifted in from above lane 7 read as 0 before extension.
- Store writeback: out_data_o = 0 and out_rd_o = 0, so no register write.
- Mid-operation reset: the outstanding request is abandoned and mem_req_o drops on the next cycle. The memory shares rst and discards in-flight transactions.

Optional Feature:
- Macro: YSYX_22040895_LSU_MISALIGN_EN.
- When defined:
  - Adds output port misalign_o (1 bit), registered, reset 0.
  - A load/store is misaligned if: H size with addr[0]=1; W size with addr[1:0]!=0; D size with addr[2:0]!=0.
  - A misaligned access issues no mem_req_o and goes directly to OUT with misalign_o=1, out_data_o=0, out_rd_o=0.
  - misalign_o clears when the OUT handshake completes.
- When undefined:
  - The port is absent; all accesses are performed with the lane truncation above.

Test Plan:
- Non-mem op, addr_i=0x2A, rd_i=5 -> out_valid_o=1 next cycle, out_data_o=0x2A, out_rd_o=5, mem_req_o never asserted.
- LB at 0x80000003 with rdata=0x00000000_F2000000 -> mem_addr_o=0x80000000, mem_we_o=0, out_data_o=0xFFFFFFFF_FFFFFFF2.
- LWU at 0x80000004 with rdata=0x80000001_00000000 -> out_data_o=0x00000000_80000001. Same access as LW -> 0xFFFFFFFF_80000001.
- SW addr=0x80000004, wdata_i=0x12345678 -> mem_we_o=1, wmask=0xF0, mem_wdata_o=0x12345678_00000000; on ack, out_data_o=0, out_rd_o=0.
- Backpressure: grant delayed 3 cycles, then out_ready_i low 2 cycles -> mem_req_o and mem_addr_o stable through REQ; out_data_o held; in_ready_o=0 until the OUT handshake completes.
- LH at 0x80000001 -> with the macro: misalign_o=1, no mem_req_o. Without the macro: wmask/lanes from off=1, normal completion. Additionally, asserting rst during REQ -> mem_req_o=0 and state IDLE on the next cycle.
